// File: rtl/mips_mem_pkg.sv
// Shared MIPS memory-side definitions.
// Holds the data-memory responder FSM state type, the machine word width and
// the byte-offset width of a word address, plus the address legality check
// used by the data-memory responder.
package mips_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // A byte address is illegal when it is not word aligned or when its word
  // index lies at or beyond the end of the array. The index comparison is
  // done on the full 30-bit word index, so high addresses never alias.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    logic [WORD_W-1:0] word_idx;
    word_idx = {{BYTE_OFF_W{1'b0}}, addr[WORD_W-1:BYTE_OFF_W]};
    return (addr[BYTE_OFF_W-1:0] != '0) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and dmem_responder.
//   req_valid/req_ready  : request handshake
//   req_write            : 1 = store word, 0 = load word
//   req_addr/req_wdata   : byte address and store data
//   resp_valid/resp_ready: response handshake
//   resp_rdata/resp_err  : load data (0 for stores/errors), error flag
// Modports: master = initiator side, slave = responder side.
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_ram_array.sv
// Word storage for the data-memory responder: DEPTH x WORD_W, one synchronous
// write port and one combinational read port. Contents are not reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : word index written on the rising edge when we=1
//   wdata : word written
//   raddr : word index read combinationally
//   rdata : word at raddr
module ram_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with a programmable number of wait states.
// One request is outstanding at a time: IDLE accepts, WAIT counts down the
// wait states, RESP presents the response until the initiator takes it.
// Misaligned or out-of-range addresses return resp_err=1 and never write.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : dmem_responder_if.slave request/response bus
// Parameters:
//   DEPTH       : number of 32-bit words held
//   WAIT_CYCLES : wait states between accept and response (0..15)
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lat_write_q;
  logic [WORD_W-1:0] lat_addr_q;
  logic [WORD_W-1:0] lat_wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              enter_resp;
  logic              cur_write;
  logic              cur_err;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [AW-1:0]     cur_idx;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  // req_ready is gated by reset itself so it reads 0 while reset is held.
  assign bus.req_ready  = (state_q == IDLE) && reset;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // With zero wait states the response is formed on the accept edge, before
  // the latches hold anything, so the live bus values stand in for them.
  assign cur_write = (state_q == IDLE) ? bus.req_write : lat_write_q;
  assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata_q;
  assign cur_err   = addr_err(cur_addr, DEPTH);
  assign cur_idx   = cur_addr[AW+BYTE_OFF_W-1:BYTE_OFF_W];

  // The only memory write is on the edge entering RESP, so a request
  // abandoned by reset in WAIT never reaches the array.
  assign ram_we = enter_resp && cur_write && !cur_err;

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        lat_write_q <= bus.req_write;
        lat_addr_q  <= bus.req_addr;
        lat_wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_write || cur_err) ? '0 : ram_rdata;
      end else if ((state_q == RESP) && bus.resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words held.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (0..15 legal).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; block held in reset while low.
REQ-005 req_valid  input  1  initiator presents a data-memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address (ALU result of LW/SW).
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  initiator accepts response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-015 Request accepted when req_valid & req_ready; write flag, address and wdata latched on that edge; later input changes ignored.
REQ-016 IDLE -> WAIT on accept with WAIT_CYCLES>0, wait counter loaded with WAIT_CYCLES-1; IDLE -> RESP on accept with WAIT_CYCLES=0.
REQ-017 WAIT decrements the counter each cycle; WAIT -> RESP on the cycle the counter is 0.
REQ-018 Latency: accept at edge N -> resp_valid high in cycle N+1+WAIT_CYCLES exactly.
REQ-019 RESP holds resp_valid, resp_rdata, resp_err stable until resp_valid & resp_ready; RESP -> IDLE on that edge; no new request accepted in the same cycle (one outstanding request maximum).
REQ-020 Error: req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH -> resp_err=1, resp_rdata=0, no memory write.
REQ-021 Valid store: memory word req_addr[31:2] written exactly once, on the edge entering RESP; resp_rdata=0, resp_err=0.
REQ-022 Valid load: resp_rdata = word at req_addr[31:2] as of the edge entering RESP; stable through RESP.
REQ-023 Load from a word written by the previous store SHALL return the new value.
REQ-024 req_valid deasserted while req_ready=1 -> no state change; resp_ready ignored outside RESP.
REQ-025 Address arithmetic on 32-bit unsigned values; no wrap-around aliasing above DEPTH (REQ-020 applies).

Reset
REQ-026 reset low -> state IDLE, counter 0, latched request cleared, req_ready=0 while low and 1 on the first cycle after release, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 Reset during WAIT discards the pending request; a pending store SHALL NOT modify memory.
REQ-028 Memory array contents are not reset; content after power-up is undefined until written.

Structure
REQ-029 Shared package mips_mem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), WORD_W=32 and the byte-offset width constant; the MIPS core and this block share it.
REQ-030 Storage SHALL be a separate sub-module ram_array (one synchronous write port, one combinational read port, DEPTH x 32); the FSM and latches live in dmem_responder.

Verification
REQ-031 WAIT_CYCLES=2: store addr 0x8 data 0xDEADBEEF accepted cycle 0 -> resp_valid cycle 3, err=0; then load 0x8 -> resp_rdata=0xDEADBEEF, err=0.
REQ-032 Load addr 0x6 (misaligned) and load addr 0x100 with DEPTH=64 -> resp_err=1, resp_rdata=0; follow-up load of any valid word unchanged.
REQ-033 resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable 5 cycles, req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-034 Store 0x0 data 0x12345678, reset asserted during WAIT -> after release req_ready=1, resp_valid=0; load 0x0 returns the prior value, not 0x12345678.
REQ-035 WAIT_CYCLES=0: back-to-back stores to 0x0 and 0x4 with resp_ready tied 1 -> each response one cycle after accept, one accept every 2 cycles; loads return both values.
REQ-036 req_addr/req_wdata changed while in WAIT -> response reflects values latched at accept.
